// File: rtl/interrupt_request_arbiter.sv
// Interrupt request arbiter: edge-latched pending bits, masked fixed-priority pick, one-cycle pulse.
// Optional IRQ_SYNC_EN adds a 2-flop input synchronizer per line.
//
//   state   | meaning
//   IDLE    | waiting for an eligible request while not stalled
//   SERVICE | pulse issued, waiting for return_from_isr
//   GUARD   | post-return holdoff, no pulse allowed
module interrupt_request_arbiter #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3,
  parameter int HOLDOFF = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               stall,
  input  logic               return_from_isr,
  output logic               interupt_signal,
  output logic [ID_W-1:0]    irq_id,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending
);

  localparam int CNT_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVICE = 2'd1,
    GUARD   = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] pending_nxt;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    id_nxt;
  logic               pulse_nxt;
  logic               svc_nxt;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] irq_sync1, irq_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_sync1 <= '0;
      irq_sync2 <= '0;
    end else begin
      irq_sync1 <= irq_in;
      irq_sync2 <= irq_sync1;
    end
  end

  assign irq_s = irq_sync2;
`else
  assign irq_s = irq_in;
`endif

  assign eligible = pending & irq_mask;

  // Descending scan so the lowest eligible index is the last assignment.
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = i[ID_W-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    id_nxt    = irq_id;
    svc_nxt   = in_service;
    clr       = '0;
    case (state)
      IDLE: begin
        if ((|eligible) && !stall) begin
          pulse_nxt = 1'b1;
          id_nxt    = winner;
          clr       = {{(NUM_IRQ-1){1'b0}}, 1'b1} << winner;
          svc_nxt   = 1'b1;
          state_nxt = SERVICE;
        end
      end
      SERVICE: begin
        // A return coinciding with the pulse cycle belongs to no real ISR.
        if (return_from_isr && !interupt_signal) begin
          svc_nxt = 1'b0;
          if (HOLDOFF == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = GUARD;
            cnt_nxt   = CNT_W'(HOLDOFF);
          end
        end
      end
      GUARD: begin
        if (cnt <= CNT_W'(1)) state_nxt = IDLE;
        else                  cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
    // New edge overrides the winner clear on the same bit.
    pending_nxt = (pending & ~clr) | (irq_s & ~irq_prev);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      irq_prev        <= '0;
      pending         <= '0;
      interupt_signal <= 1'b0;
      irq_id          <= '0;
      in_service      <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      irq_prev        <= irq_s;
      pending         <= pending_nxt;
      interupt_signal <= pulse_nxt;
      irq_id          <= id_nxt;
      in_service      <= svc_nxt;
    end
  end

endmodule
